// File: rtl/filter_run_ctrl.sv
// -----------------------------------------------------------------------------
// filter_run_ctrl
//
// Run sequencer for the filter GPU. It turns the four active-low kernel
// pushbuttons into clean press events, selects the kernel program fetched from
// instruction memory, and holds the GPU in reset until a run is requested.
// When a run is requested it releases the GPU for exactly one frame pass. It
// counts data-memory writes to detect completion and raises a sticky timeout
// flag if the frame never finishes. It also tells the VGA path when the
// filtered frame in vector memory is valid.
//
// Ports
//   CLK            in   system clock
//   reset          in   asynchronous, active-high reset
//   kernel1        in   active-low raw button, selects kernel 00
//   kernel2        in   active-low raw button, selects kernel 01
//   kernel3        in   active-low raw button, selects kernel 10
//   identity       in   active-low raw button, selects kernel 11 (identity)
//   gpu_mem_write  in   MemWrite strobe from filterGPU
//   kernel         out  [1:0] kernel select to imem
//   gpu_rst        out  reset to filterGPU (also forces its PC to 0)
//   gpu_run        out  clock enable to filterGPU
//   busy           out  high while arming or running
//   frame_done     out  one-cycle pulse when a frame completes
//   show_result    out  1 when the filtered frame is valid for display
//   write_count    out  [CNT_W-1:0] writes counted in the current run
//   timeout        out  sticky error flag, cleared when the next run arms
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module filter_run_ctrl #(
  parameter int DEBOUNCE       = 16,
  parameter int RST_CYCLES     = 4,
  parameter int FRAME_WRITES   = 102400,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter bit AUTO_START     = 1'b1,
  parameter int CNT_W          = 19
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             kernel1,
  input  logic             kernel2,
  input  logic             kernel3,
  input  logic             identity,
  input  logic             gpu_mem_write,
  output logic [1:0]       kernel,
  output logic             gpu_rst,
  output logic             gpu_run,
  output logic             busy,
  output logic             frame_done,
  output logic             show_result,
  output logic [CNT_W-1:0] write_count,
  output logic             timeout
);

  localparam int NBTN  = 4;
  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam int ARM_W = $clog2(RST_CYCLES + 1);
  localparam int RUN_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_e;

  // ---------------------------------------------------------------------------
  // Button conditioning
  // Bit order follows press priority: bit 0 (kernel1) wins over bit 3.
  // ---------------------------------------------------------------------------
  logic [NBTN-1:0]           btn_raw;
  logic [NBTN-1:0]           sync1_q;
  logic [NBTN-1:0]           sync2_q;
  logic [NBTN-1:0]           armed_q;
  logic [NBTN-1:0]           armed_d;
  logic [NBTN-1:0][DB_W-1:0] db_cnt_q;
  logic [NBTN-1:0][DB_W-1:0] db_cnt_d;
  logic [NBTN-1:0]           press_evt;
  logic                      any_evt;
  logic [1:0]                evt_code;

  assign btn_raw = {identity, kernel3, kernel2, kernel1};

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      // Synchronizers come up at the released level so a reset never looks
      // like a press.
      sync1_q  <= '1;
      sync2_q  <= '1;
      armed_q  <= '1;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      armed_q  <= armed_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // An armed button counts consecutive low cycles and fires on the DEBOUNCE-th.
  // It then waits for DEBOUNCE consecutive high cycles before re-arming, so a
  // held button produces exactly one event. Any glitch restarts the count.
  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    press_evt = '0;
    armed_d   = armed_q;
    db_cnt_d  = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (armed_q[i]) begin
        if (!sync2_q[i]) begin
          if (db_cnt_q[i] == DB_W'(DEBOUNCE - 1)) begin
            press_evt[i] = 1'b1;
            armed_d[i]   = 1'b0;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + 1'b1;
          end
        end
      end else begin
        if (sync2_q[i]) begin
          if (db_cnt_q[i] == DB_W'(DEBOUNCE - 1)) begin
            armed_d[i] = 1'b1;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  // Same-cycle events resolve to the highest-priority button.
  always_comb begin
    any_evt  = |press_evt;
    evt_code = 2'd0;
    if (press_evt[0]) begin
      evt_code = 2'd0;
    end else if (press_evt[1]) begin
      evt_code = 2'd1;
    end else if (press_evt[2]) begin
      evt_code = 2'd2;
    end else if (press_evt[3]) begin
      evt_code = 2'd3;
    end
  end

  // ---------------------------------------------------------------------------
  // Run sequencer
  // ---------------------------------------------------------------------------
  state_e             state_q,       state_d;
  logic               auto_q,        auto_d;
  logic [1:0]         kernel_q,      kernel_d;
  logic               pend_vld_q,    pend_vld_d;
  logic [1:0]         pend_code_q,   pend_code_d;
  logic [ARM_W-1:0]   arm_cnt_q,     arm_cnt_d;
  logic [RUN_W-1:0]   run_cnt_q,     run_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q,      wr_cnt_d;
  logic               show_q,        show_d;
  logic               timeout_q,     timeout_d;
  logic               gpu_rst_q;
  logic               gpu_run_q;
  logic               busy_q;
  logic               frame_done_q;
  logic               frame_complete;

  always_comb begin
    state_d        = state_q;
    auto_d         = auto_q;
    kernel_d       = kernel_q;
    pend_vld_d     = pend_vld_q;
    pend_code_d    = pend_code_q;
    arm_cnt_d      = '0;
    run_cnt_d      = '0;
    wr_cnt_d       = wr_cnt_q;
    show_d         = show_q;
    timeout_d      = timeout_q;
    frame_complete = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_evt) begin
          state_d  = S_ARM;
          kernel_d = evt_code;
          auto_d   = 1'b0;
        end else if (auto_q) begin
          // One-shot power-up run with the default kernel.
          state_d  = S_ARM;
          kernel_d = 2'd0;
          auto_d   = 1'b0;
        end
      end

      S_ARM: begin
        if (any_evt) begin
          pend_vld_d  = 1'b1;
          pend_code_d = evt_code;
        end
        if (arm_cnt_q == ARM_W'(RST_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        if (any_evt) begin
          pend_vld_d  = 1'b1;
          pend_code_d = evt_code;
        end
        if (gpu_mem_write) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          frame_complete = (wr_cnt_q == CNT_W'(FRAME_WRITES - 1));
        end
        // Completion takes precedence over a timeout on the same cycle.
        if (frame_complete) begin
          state_d = S_DONE;
        end else if (run_cnt_q == RUN_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ERROR;
        end
      end

      S_DONE: begin
        // A press landing exactly on the DONE cycle is newer than anything
        // queued, so it wins under last-press-wins.
        if (any_evt) begin
          state_d  = S_ARM;
          kernel_d = evt_code;
        end else if (pend_vld_q) begin
          state_d  = S_ARM;
          kernel_d = pend_code_q;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ERROR: begin
        if (any_evt) begin
          state_d  = S_ARM;
          kernel_d = evt_code;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Entry actions, keyed on the transition so the registered outputs change
    // on the same edge as the state.
    if (state_d == S_ARM && state_q != S_ARM) begin
      wr_cnt_d   = '0;
      show_d     = 1'b0;
      timeout_d  = 1'b0;
      // Whatever was queued has either just been consumed or is stale.
      pend_vld_d = 1'b0;
    end
    if (state_d == S_DONE && state_q != S_DONE) begin
      show_d = 1'b1;
    end
    if (state_d == S_ERROR && state_q != S_ERROR) begin
      show_d    = 1'b0;
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      auto_q       <= AUTO_START;
      kernel_q     <= 2'd0;
      pend_vld_q   <= 1'b0;
      pend_code_q  <= 2'd0;
      arm_cnt_q    <= '0;
      run_cnt_q    <= '0;
      wr_cnt_q     <= '0;
      show_q       <= 1'b0;
      timeout_q    <= 1'b0;
      gpu_rst_q    <= 1'b1;
      gpu_run_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      auto_q       <= auto_d;
      kernel_q     <= kernel_d;
      pend_vld_q   <= pend_vld_d;
      pend_code_q  <= pend_code_d;
      arm_cnt_q    <= arm_cnt_d;
      run_cnt_q    <= run_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      show_q       <= show_d;
      timeout_q    <= timeout_d;
      // Strobes are decoded from the next state so they line up with state_q.
      gpu_rst_q    <= (state_d != S_RUN);
      gpu_run_q    <= (state_d == S_RUN);
      busy_q       <= (state_d == S_ARM) || (state_d == S_RUN);
      frame_done_q <= (state_d == S_DONE);
    end
  end

  assign kernel      = kernel_q;
  assign gpu_rst     = gpu_rst_q;
  assign gpu_run     = gpu_run_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign show_result = show_q;
  assign write_count = wr_cnt_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_filter_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_filter_run_ctrl
//
// Scoreboard bench for filter_run_ctrl. The stimulus thread pushes the events
// it expects (arm, frame done, timeout) with their kernel codes, derived from
// the button masks it drives. A negedge monitor pops one entry whenever the
// DUT shows such an event and checks the outputs against it.
// -----------------------------------------------------------------------------
module tb_filter_run_ctrl;

  localparam int DEBOUNCE       = 4;
  localparam int RST_CYCLES     = 2;
  localparam int FRAME_WRITES   = 8;
  localparam int TIMEOUT_CYCLES = 50;
  localparam int CNT_W          = 19;

  typedef enum int {EV_ARM, EV_DONE, EV_ERR} ev_e;

  typedef struct {
    ev_e kind;
    int  kern;
    int  wc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       btn_n;          // bit0 kernel1 .. bit3 identity, active low
  logic             gpu_mem_write;
  logic [1:0]       kernel;
  logic             gpu_rst;
  logic             gpu_run;
  logic             busy;
  logic             frame_done;
  logic             show_result;
  logic [CNT_W-1:0] write_count;
  logic             timeout;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  filter_run_ctrl #(
    .DEBOUNCE       (DEBOUNCE),
    .RST_CYCLES     (RST_CYCLES),
    .FRAME_WRITES   (FRAME_WRITES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .AUTO_START     (1'b1),
    .CNT_W          (CNT_W)
  ) dut (
    .CLK           (clk),
    .reset         (reset),
    .kernel1       (btn_n[0]),
    .kernel2       (btn_n[1]),
    .kernel3       (btn_n[2]),
    .identity      (btn_n[3]),
    .gpu_mem_write (gpu_mem_write),
    .kernel        (kernel),
    .gpu_rst       (gpu_rst),
    .gpu_run       (gpu_run),
    .busy          (busy),
    .frame_done    (frame_done),
    .show_result   (show_result),
    .write_count   (write_count),
    .timeout       (timeout)
  );

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model helpers
  // ---------------------------------------------------------------------------
  // Lowest-numbered pressed button wins; its index is the kernel code.
  function automatic int prio(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) if (mask[i]) return i;
    return -1;
  endfunction

  task automatic push(input ev_e kind, input int kern, input int wc);
    exp_t e;
    e.kind = kind;
    e.kern = kern;
    e.wc   = wc;
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers; all of them return at posedge + 1
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] mask, input int bounce);
    for (int i = 0; i < bounce; i++) begin
      if (i % 2 == 0) btn_n = btn_n & ~mask;
      else            btn_n = btn_n | mask;
      step(1);
    end
    btn_n = btn_n & ~mask;
  endtask

  task automatic release_btn(input logic [3:0] mask);
    btn_n = btn_n | mask;
    step(DEBOUNCE + 4);
  endtask

  task automatic do_writes(input int n);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 2));
      gpu_mem_write = 1'b1;
      step(1);
      gpu_mem_write = 1'b0;
    end
  endtask

  task automatic wait_run(input string name);
    int n = 0;
    while (!gpu_run && n < 60) begin
      step(1);
      n++;
    end
    check({"wait_run_", name}, gpu_run, 1);
  endtask

  task automatic wait_timeout(input string name);
    int n = 0;
    while (!timeout && n < 80) begin
      step(1);
      n++;
    end
    check({"wait_timeout_", name}, timeout, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int   cur_kernel = 0;
  int   arm_len    = 0;
  logic prev_busy  = 1'b0;
  logic prev_run   = 1'b0;
  logic prev_fd    = 1'b0;
  logic prev_to    = 1'b0;

  task automatic pop_check(input ev_e kind, input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({"unexpected_", tag}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_kind"}, kind, e.kind);
    check({tag, "_kernel"}, kernel, e.kern);
    case (kind)
      EV_ARM: begin
        check("arm_write_count", write_count, 0);
        check("arm_show_result", show_result, 0);
        check("arm_timeout", timeout, 0);
        check("arm_gpu_rst", gpu_rst, 1);
        cur_kernel = e.kern;
      end
      EV_DONE: begin
        check("done_write_count", write_count, FRAME_WRITES);
        check("done_show_result", show_result, 1);
        check("done_busy", busy, 0);
        check("done_gpu_run", gpu_run, 0);
      end
      default: begin
        check("err_write_count", write_count, e.wc);
        check("err_show_result", show_result, 0);
        check("err_gpu_rst", gpu_rst, 1);
        check("err_busy", busy, 0);
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
      prev_run  = 1'b0;
      prev_fd   = 1'b0;
      prev_to   = 1'b0;
      arm_len   = 0;
    end else begin
      check("rst_run_excl", gpu_rst, !gpu_run);
      if (busy && !gpu_run) arm_len = (prev_busy && !prev_run) ? arm_len + 1 : 1;
      if (gpu_run && !prev_run) check("arm_cycles", arm_len, RST_CYCLES);
      if (gpu_run) check("run_kernel_stable", kernel, cur_kernel);
      if (prev_fd) check("frame_done_width", frame_done, 0);
      if (busy && !prev_busy) pop_check(EV_ARM, "arm");
      if (frame_done) pop_check(EV_DONE, "done");
      if (timeout && !prev_to) pop_check(EV_ERR, "err");
      prev_busy = busy;
      prev_run  = gpu_run;
      prev_fd   = frame_done;
      prev_to   = timeout;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:0] mask;
    logic [3:0] pmask;
    int         k;
    int         pk;
    int         mode;
    int         nw;
    int         w1;

    reset         = 1'b1;
    btn_n         = 4'hF;
    gpu_mem_write = 1'b0;
    step(2);

    // Reset values
    check("rst_kernel", kernel, 0);
    check("rst_gpu_rst", gpu_rst, 1);
    check("rst_gpu_run", gpu_run, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_show_result", show_result, 0);
    check("rst_write_count", write_count, 0);
    check("rst_timeout", timeout, 0);

    // 1: auto-start run with kernel 00
    push(EV_ARM, 0, 0);
    push(EV_DONE, 0, 0);
    reset = 1'b0;
    step(1);
    check("t1_auto_arm", busy, 1);
    wait_run("t1");
    do_writes(FRAME_WRITES);
    check("t1_frame_done", frame_done, 1);
    step(1);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_gpu_rst", gpu_rst, 1);
    check("t1_idle_show", show_result, 1);
    check("t1_idle_wc", write_count, FRAME_WRITES);
    check("t1_idle_kernel", kernel, 0);
    do_writes(3);
    check("t1_idle_writes_ignored", write_count, FRAME_WRITES);

    // 2: bouncy kernel3 press, held long, then released
    push(EV_ARM, 2, 0);
    push(EV_DONE, 2, 0);
    press(4'b0100, 3);
    wait_run("t2");
    do_writes(FRAME_WRITES);
    step(1);
    release_btn(4'b0100);
    step(10);
    check("t2_no_retrigger", exp_q.size(), 0);
    check("t2_idle", busy, 0);

    // 3: kernel2 and identity in the same cycle
    push(EV_ARM, 1, 0);
    push(EV_DONE, 1, 0);
    press(4'b1010, 0);
    wait_run("t3");
    do_writes(FRAME_WRITES);
    step(1);
    release_btn(4'b1010);

    // 4: identity pressed mid-run queues the next run
    push(EV_ARM, 1, 0);
    push(EV_DONE, 1, 0);
    push(EV_ARM, 3, 0);
    push(EV_DONE, 3, 0);
    press(4'b0010, 0);
    wait_run("t4");
    do_writes(3);
    press(4'b1000, 0);
    step(DEBOUNCE + 4);
    check("t4_kernel_held", kernel, 1);
    do_writes(FRAME_WRITES - 3);
    wait_run("t4_pending");
    do_writes(FRAME_WRITES);
    step(1);
    release_btn(4'b1010);
    check("t4_idle", busy, 0);

    // 5: timeout, then recovery with kernel1
    push(EV_ARM, 2, 0);
    push(EV_ERR, 2, 0);
    press(4'b0100, 1);
    wait_run("t5");
    wait_timeout("t5");
    check("t5_gpu_rst", gpu_rst, 1);
    check("t5_show", show_result, 0);
    release_btn(4'b0100);
    do_writes(2);
    check("t5_err_writes_ignored", write_count, 0);
    check("t5_timeout_sticky", timeout, 1);
    push(EV_ARM, 0, 0);
    push(EV_DONE, 0, 0);
    press(4'b0001, 0);
    wait_run("t5_recover");
    do_writes(FRAME_WRITES);
    step(1);
    release_btn(4'b0001);

    // 6: reset mid-run with a queued identity request
    push(EV_ARM, 2, 0);
    push(EV_DONE, 2, 0);
    press(4'b0100, 0);
    wait_run("t6");
    do_writes(3);
    press(4'b1000, 0);
    step(DEBOUNCE + 4);
    release_btn(4'b1000);
    do_writes(2);
    check("t6_wc_before_reset", write_count, 5);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_gpu_rst", gpu_rst, 1);
    check("t6_rst_gpu_run", gpu_run, 0);
    check("t6_rst_wc", write_count, 0);
    check("t6_rst_kernel", kernel, 0);
    check("t6_rst_busy", busy, 0);
    exp_q.delete();
    btn_n = 4'hF;
    step(2);
    push(EV_ARM, 0, 0);
    push(EV_DONE, 0, 0);
    reset = 1'b0;
    wait_run("t6_after");
    do_writes(FRAME_WRITES);
    step(12);
    check("t6_pending_discarded", exp_q.size(), 0);
    check("t6_idle", busy, 0);

    // Randomized runs: plain, with a queued press, or timing out
    for (int it = 0; it < 10; it++) begin
      mask = 4'($urandom_range(1, 15));
      k    = prio(mask);
      mode = $urandom_range(0, 2);
      pmask = 4'($urandom_range(1, 15)) & ~mask;
      if (mode == 2 && pmask == 4'd0) mode = 1;
      push(EV_ARM, k, 0);
      if (mode == 0) begin
        nw = $urandom_range(0, FRAME_WRITES - 1);
        push(EV_ERR, k, nw);
        press(mask, $urandom_range(0, 3));
        wait_run("rnd_to");
        do_writes(nw);
        wait_timeout("rnd");
        release_btn(mask);
      end else if (mode == 1) begin
        push(EV_DONE, k, 0);
        press(mask, $urandom_range(0, 3));
        wait_run("rnd");
        do_writes(FRAME_WRITES);
        step(1);
        release_btn(mask);
      end else begin
        pk = prio(pmask);
        push(EV_DONE, k, 0);
        push(EV_ARM, pk, 0);
        push(EV_DONE, pk, 0);
        press(mask, $urandom_range(0, 3));
        wait_run("rnd_q");
        w1 = $urandom_range(0, 4);
        do_writes(w1);
        press(pmask, 0);
        step(DEBOUNCE + 4);
        do_writes(FRAME_WRITES - w1);
        wait_run("rnd_pending");
        do_writes(FRAME_WRITES);
        step(1);
        release_btn(mask | pmask);
      end
    end

    step(5);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
